// File: rtl/cam_frame_tx.sv
// cam_frame_tx: synthetic OV7670-style camera bus transmitter.
// Emits CAM_PCLK (clk/2), CAM_VSYNC, CAM_HREF and RGB444 pixel bytes
// built from one of four test patterns, one frame per enable request.
module cam_frame_tx #(
  parameter int          H_PIXELS    = 160,
  parameter int          V_LINES     = 120,
  parameter int          H_BLANK     = 40,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BP_LINES  = 5,
  parameter int          V_FP_LINES  = 2,
  parameter logic [11:0] SOLID_RGB   = 12'hF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern,
  output logic       CAM_PCLK,
  output logic       CAM_VSYNC,
  output logic       CAM_HREF,
  output logic [7:0] CAM_px_data,
  output logic       frame_done
);

  localparam int LINE_LEN = 2 * H_PIXELS + H_BLANK;
  localparam int BAR_W    = H_PIXELS / 8;

  localparam logic [11:0] COL_LAST = 12'(LINE_LEN - 1);
  localparam logic [11:0] ACT_LAST = 12'(2 * H_PIXELS - 1);
  localparam logic [11:0] VL_LAST  = 12'(V_LINES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_HBLANK = 3'd4;
  localparam logic [2:0] ST_VFP    = 3'd5;

  logic        pclk_q,  pclk_d;
  logic [2:0]  state_q, state_d;
  logic [11:0] col_q,   col_d;
  logic [11:0] line_q,  line_d;
  logic [1:0]  pat_q,   pat_d;
  logic        vsync_q, vsync_d;
  logic        href_q,  href_d;
  logic [7:0]  data_q,  data_d;
  logic        done_q,  done_d;

  logic        tick;
  logic [11:0] phase_last;
  logic [11:0] pix_x;
  logic [11:0] bar_idx;
  logic [2:0]  bar;
  logic [11:0] rgb;

  // Everything except the PCLK toggle advances only on the clk edge where PCLK falls.
  assign tick = pclk_q;

  // Number of line-times minus one spent in the current vertical blanking phase.
  always_comb begin
    phase_last = '0;
    case (state_q)
      ST_VSYNC: phase_last = 12'(VSYNC_LINES - 1);
      ST_VBP:   phase_last = 12'(V_BP_LINES - 1);
      ST_VFP:   phase_last = 12'(V_FP_LINES - 1);
      default:  phase_last = '0;
    endcase
  end

  // Frame sequencer: state, column/line counters, pattern latch, end-of-frame pulse.
  always_comb begin
    pclk_d  = ~pclk_q;
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_VSYNC;
            col_d   = '0;
            line_d  = '0;
            pat_d   = pattern;
          end
        end
        ST_VSYNC, ST_VBP, ST_VFP: begin
          col_d = col_q + 12'd1;
          if (col_q == COL_LAST) begin
            col_d  = '0;
            line_d = line_q + 12'd1;
            if (line_q == phase_last) begin
              line_d = '0;
              case (state_q)
                ST_VSYNC: state_d = ST_VBP;
                ST_VBP:   state_d = ST_ACTIVE;
                default: begin
                  done_d = 1'b1;
                  if (enable) begin
                    state_d = ST_VSYNC;
                    pat_d   = pattern;
                  end else begin
                    state_d = ST_IDLE;
                  end
                end
              endcase
            end
          end
        end
        ST_ACTIVE: begin
          // Column keeps counting through HBLANK so one counter spans the whole line.
          col_d = col_q + 12'd1;
          if (col_q == ACT_LAST) state_d = ST_HBLANK;
        end
        ST_HBLANK: begin
          col_d = col_q + 12'd1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (line_q == VL_LAST) begin
              line_d  = '0;
              state_d = ST_VFP;
            end else begin
              line_d  = line_q + 12'd1;
              state_d = ST_ACTIVE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pixel colour for the position about to be driven (next column / next line).
  always_comb begin
    pix_x   = {1'b0, col_d[11:1]};
    bar_idx = pix_x / 12'(BAR_W);
    bar     = (bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0];
    rgb     = SOLID_RGB;
    case (pat_q)
      2'd0: rgb = SOLID_RGB;
      2'd1: begin
        case (bar)
          3'd0:    rgb = 12'hFFF;
          3'd1:    rgb = 12'hFF0;
          3'd2:    rgb = 12'h0FF;
          3'd3:    rgb = 12'h0F0;
          3'd4:    rgb = 12'hF0F;
          3'd5:    rgb = 12'hF00;
          3'd6:    rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd2:    rgb = {pix_x[3:0], line_d[3:0], pix_x[7:4]};
      default: rgb = (pix_x[3] ^ line_d[3]) ? 12'h000 : 12'hFFF;
    endcase
  end

  // Bus outputs are registered from the next state so they change together on a tick.
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (tick) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE);
      if (state_d == ST_ACTIVE) data_d = col_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
      else                      data_d = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_q  <= 1'b0;
      state_q <= ST_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      pat_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      pclk_q  <= pclk_d;
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign CAM_PCLK    = pclk_q;
  assign CAM_VSYNC   = vsync_q;
  assign CAM_HREF    = href_q;
  assign CAM_px_data = data_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_cam_frame_tx.sv
// Testbench for cam_frame_tx with a reduced vertical geometry so several
// whole frames fit in a short run; the line stays at 160 pixels.
module tb_cam_frame_tx;

  localparam int HP    = 160;
  localparam int VL    = 8;
  localparam int HB    = 4;
  localparam int LLEN  = 2 * HP + HB;       // 324
  localparam int FRAME = (1 + 1 + VL + 1) * LLEN;  // 3564 PCLK periods

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] pattern;
  logic       CAM_PCLK, CAM_VSYNC, CAM_HREF, frame_done;
  logic [7:0] CAM_px_data;

  int errors = 0;
  int checks = 0;
  int fd_total = 0;

  logic [7:0] cap [0:VL-1][0:2*HP-1];
  int vs_cnt, first_href, lines, bad_wid, blank_bad, fd_delta;

  cam_frame_tx #(
    .H_PIXELS(HP), .V_LINES(VL), .H_BLANK(HB),
    .VSYNC_LINES(1), .V_BP_LINES(1), .V_FP_LINES(1), .SOLID_RGB(12'hF00)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
    .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_total++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected byte for pixel (x,y); odd selects the {G,B} byte.
  function automatic logic [7:0] exp_byte(input logic [1:0] pat, input int x, input int y, input bit odd);
    logic [11:0] bars [0:7];
    logic [11:0] c;
    logic [11:0] xv;
    logic [11:0] yv;
    int bi;
    bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
    bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
    xv = 12'(x);
    yv = 12'(y);
    bi = x / (HP / 8);
    if (bi > 7) bi = 7;
    case (pat)
      2'd0:    c = 12'hF00;
      2'd1:    c = bars[bi];
      2'd2:    c = {xv[3:0], yv[3:0], xv[7:4]};
      default: c = (xv[3] != yv[3]) ? 12'h000 : 12'hFFF;
    endcase
    return odd ? c[7:0] : {4'h0, c[11:8]};
  endfunction

  // Advance to the next sample point: a clk falling edge with PCLK high.
  task automatic pstep();
    @(negedge clk);
    if (CAM_PCLK !== 1'b1) @(negedge clk);
  endtask

  task automatic wait_vsync(input string tag);
    int n;
    n = 0;
    pstep();
    while (CAM_VSYNC !== 1'b1 && n < 10) begin
      pstep();
      n++;
    end
    check(tag, int'(CAM_VSYNC), 1);
  endtask

  // Walks one frame starting at the current sample (first VSYNC period),
  // then steps once more onto the first period after the frame.
  task automatic run_frame(input logic [1:0] next_pat, input int drop_line);
    int b;
    int fd0;
    logic href_prev;
    vs_cnt = 0; first_href = -1; lines = 0; bad_wid = 0; blank_bad = 0;
    b = 0; href_prev = 1'b0; fd0 = fd_total;
    for (int p = 0; p < FRAME; p++) begin
      if (p != 0) pstep();
      if (p == 0) pattern = next_pat;
      if (CAM_VSYNC === 1'b1) vs_cnt++;
      if (CAM_HREF === 1'b1) begin
        if (!href_prev) begin
          if (first_href < 0) first_href = p;
          b = 0;
        end
        if (lines < VL && b < 2 * HP) cap[lines][b] = CAM_px_data;
        b++;
        if (lines == drop_line && b == 10) enable = 1'b0;
      end else begin
        if (href_prev) begin
          if (b != 2 * HP) bad_wid++;
          lines++;
        end
        if (CAM_px_data !== 8'h00) blank_bad++;
      end
      href_prev = CAM_HREF;
    end
    pstep();
    fd_delta = fd_total - fd0;
  endtask

  task automatic check_frame(input logic [1:0] pat);
    int mism;
    mism = 0;
    check($sformatf("vsync_len_p%0d", pat), vs_cnt, LLEN);
    check($sformatf("first_href_p%0d", pat), first_href, 2 * LLEN);
    check($sformatf("href_lines_p%0d", pat), lines, VL);
    check($sformatf("href_width_p%0d", pat), bad_wid, 0);
    check($sformatf("blank_data_p%0d", pat), blank_bad, 0);
    check($sformatf("frame_done_p%0d", pat), fd_delta, 1);
    for (int y = 0; y < VL; y++)
      for (int bb = 0; bb < 2 * HP; bb++)
        if (cap[y][bb] !== exp_byte(pat, bb / 2, y, bb[0])) mism++;
    check($sformatf("pixels_p%0d", pat), mism, 0);
  endtask

  initial begin
    int notog, act, vs_seen, fd0;
    logic prev;

    rst = 1'b1; enable = 1'b0; pattern = 2'd0;
    repeat (4) @(negedge clk);
    check("rst_pclk", int'(CAM_PCLK), 0);
    check("rst_vsync", int'(CAM_VSYNC), 0);
    check("rst_href", int'(CAM_HREF), 0);
    check("rst_data", int'(CAM_px_data), 0);
    check("rst_done", int'(frame_done), 0);
    rst = 1'b0;

    // Idle with enable low: PCLK toggles, bus stays quiet.
    notog = 0; act = 0; prev = CAM_PCLK;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (CAM_PCLK === prev) notog++;
      prev = CAM_PCLK;
      if (CAM_VSYNC !== 1'b0 || CAM_HREF !== 1'b0 || CAM_px_data !== 8'h00) act++;
    end
    check("idle_pclk_toggle", notog, 0);
    check("idle_quiet", act, 0);
    check("idle_no_done", fd_total, 0);

    // Solid frame; pattern changed during the frame must not affect it.
    pattern = 2'd0;
    enable  = 1'b1;
    wait_vsync("start_p0");
    run_frame(2'd1, -1);
    check_frame(2'd0);
    check("p0_b0", int'(cap[0][0]), 8'h0F);
    check("p0_b1", int'(cap[0][1]), 8'h00);
    check("p0_last", int'(cap[7][319]), 8'h00);
    check("p0_cont_vsync", int'(CAM_VSYNC), 1);

    // Colour bars.
    run_frame(2'd2, -1);
    check_frame(2'd1);
    check("bar0_b0", int'(cap[0][0]), 8'h0F);
    check("bar0_b1", int'(cap[0][1]), 8'hFF);
    check("bar1_b40", int'(cap[0][40]), 8'h0F);
    check("bar1_b41", int'(cap[0][41]), 8'hF0);
    check("bar2_b81", int'(cap[0][81]), 8'hFF);
    check("bar2_b80", int'(cap[0][80]), 8'h00);
    check("bar7_b318", int'(cap[0][318]), 8'h00);
    check("bar7_b319", int'(cap[0][319]), 8'h00);
    check("p1_cont_vsync", int'(CAM_VSYNC), 1);

    // Gradient.
    run_frame(2'd3, -1);
    check_frame(2'd2);
    check("grad_37_5_r", int'(cap[5][74]), 8'h05);
    check("grad_37_5_gb", int'(cap[5][75]), 8'h52);
    check("grad_159_7_r", int'(cap[7][318]), 8'h0F);
    check("grad_159_7_gb", int'(cap[7][319]), 8'h79);
    check("p2_cont_vsync", int'(CAM_VSYNC), 1);

    // Checkerboard, with enable dropped in the middle of line 4.
    run_frame(2'd0, 4);
    check_frame(2'd3);
    check("chk_x0_gb", int'(cap[0][1]), 8'hFF);
    check("chk_x8_r", int'(cap[0][16]), 8'h00);
    check("chk_x8_gb", int'(cap[0][17]), 8'h00);
    check("chk_x16_gb", int'(cap[3][33]), 8'hFF);
    check("stop_vsync", int'(CAM_VSYNC), 0);
    vs_seen = 0; fd0 = fd_total;
    for (int i = 0; i < 500; i++) begin
      pstep();
      if (CAM_VSYNC !== 1'b0) vs_seen++;
    end
    check("stop_no_vsync", vs_seen, 0);
    check("stop_no_done", fd_total - fd0, 0);

    // Asynchronous reset in the middle of active line 3.
    pattern = 2'd0;
    enable  = 1'b1;
    wait_vsync("start_pre_rst");
    for (int i = 0; i < 3 * LLEN + 2 * LLEN + 80; i++) pstep();
    check("pre_rst_href", int'(CAM_HREF), 1);
    check("pre_rst_data", int'(CAM_px_data), 8'h0F);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pclk", int'(CAM_PCLK), 0);
    check("async_rst_href", int'(CAM_HREF), 0);
    check("async_rst_data", int'(CAM_px_data), 0);
    check("async_rst_vsync", int'(CAM_VSYNC), 0);
    pattern = 2'd2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_vsync("start_post_rst");
    run_frame(2'd2, -1);
    check_frame(2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
